mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output stage and valid/ready handshake.
- Two selection modes:
  - Manual: an external select picks the channel.
  - Auto-scan: an internal round-robin pointer walks all channels enabled in a mask.
- Generalises the structural 8:1 single-bit mux to arbitrary width and channel count, and adds sequencing plus backpressure.
- Feeds sampled channel data to a downstream consumer.

Parameters:
- WIDTH, 8, bits per channel.
- NUM_CH, 8, channel count; valid range is 2 to 64 (need not be a power of two).
- SEL_W, $clog2(NUM_CH), select/pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- mode  input  1  0 = manual, 1 = auto-scan.
- sel  input  SEL_W  manual channel select.
- ch_mask  input  NUM_CH  auto-scan enable per channel; bit i = 1 means channel i is eligible.
- out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
- out_valid  output  1  out_data and out_ch are valid.
- out_data  output  WIDTH  captured channel data.
- out_ch  output  SEL_W  index of the captured channel.
- sel_err  output  1  one-cycle pulse: manual load attempted with sel >= NUM_CH.

Behaviour:
- Reset (synchronous, checked at the clk edge):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - Scan pointer=0, last-served flag cleared.
- Load condition, evaluated every cycle: load = !out_valid || out_ready.
  - When load is high, the output register captures the next sample at the clock edge.
  - Latency: in_data sampled in cycle N appears on out_data in cycle N+1.
- Hold:
  - While out_valid=1 and out_ready=0, out_data, out_ch and out_valid stay stable.
  - in_data, sel, mode and ch_mask changes are ignored until the next load.
- Manual mode (mode=0):
  - On load with sel < NUM_CH: out_data = channel sel, out_ch = sel, out_valid = 1.
  - On load with sel >= NUM_CH: out_valid = 0, sel_err pulses for 1 cycle, data registers unchanged.
  - The scan pointer does not move.
- Auto-scan mode (mode=1), FSM states SCAN_FIRST and SCAN_RUN:
  - SCAN_FIRST (after reset or after entry from manual mode): the candidate search starts at the pointer, inclusive.
  - SCAN_RUN: the search starts at pointer+1, wrapping from NUM_CH-1 to 0; pointer inclusive as the last candidate.
  - On load: select the first set bit of ch_mask in search order, capture it, set pointer = that channel, out_valid=1, move to SCAN_RUN.
  - If ch_mask == 0: out_valid=0 on load, pointer unchanged, state unchanged.
  - A single enabled channel is re-selected on every load.
- Mode switch:
  - Takes effect at the next load only; held data is never disturbed.
  - Manual to auto-scan: enter SCAN_FIRST with the pointer retained.
  - Auto-scan to manual: FSM parked, pointer retained.
- Sustained throughput: with out_ready held high, one sample is accepted per cycle.
- Mid-operation reset: rst overrides load and hold; all outputs return to reset values at that edge.
- No combinational path from in_data, sel or mask to any output.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even parity (XOR-reduce) of the captured word.
  - Registered together with out_data and held with it; reset value 0.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=8, NUM_CH=8, channel i data = 8'h10+i.
1. Manual, out_ready=1, sel stepped 0..7 one per cycle.
   - out_data 8'h10..8'h17 each one cycle later; out_ch matches; out_valid=1 throughout.
2. Auto-scan, ch_mask=8'b1010_0101, out_ready=1 from reset.
   - out_ch sequence 0,2,5,7,0,2… with data 8'h10,8'h12,8'h15,8'h17,…
3. Auto-scan, out_ready=0 for 3 cycles after first valid, while in_data changes.
   - out_data stays 8'h10 and out_ch stays 0; after ready rises, the next value is channel 2.
4. Auto-scan, ch_mask=0.
   - out_valid stays 0.
   - ch_mask set to 8'h40 → out_ch=6 next cycle, repeated every cycle.
5. NUM_CH=6, manual, sel=7.
   - sel_err one-cycle pulse; out_valid=0.
   - sel=5 → out_data 8'h15.
6. rst asserted while out_valid=1 and out_ready=0.
   - Next edge: out_valid=0, out_data=0, out_ch=0.
   - Auto-scan restarts at channel 0 (inclusive).
   - With MUX_SCAN_PARITY_EN defined: out_parity = ^out_data on every valid cycle (8'h13 → 1).

Source files
------------

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select or round-robin auto-scan over a channel mask.
// Define MUX_SCAN_PARITY_EN to add an even-parity output registered with the data.
module mux_scan_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
`ifdef MUX_SCAN_PARITY_EN
    output logic                    out_parity,
`endif
    output logic                    sel_err
);

    localparam logic [0:0] SCAN_FIRST = 1'b0;
    localparam logic [0:0] SCAN_RUN   = 1'b1;

    logic [0:0]       st;
    logic [SEL_W-1:0] ptr;
    logic             load;
    logic             sel_bad;
    logic             hit;
    logic [SEL_W-1:0] scan_ch;
    logic [SEL_W-1:0] nxt_ch;
    logic [WIDTH-1:0] nxt_word;
    logic [WIDTH-1:0] ch_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_arr[g] = in_data[g*WIDTH +: WIDTH];
    end

    // First enabled channel in wrap-around order starting at p (+1 once running).
    function automatic logic [SEL_W:0] find_next(
        input logic [NUM_CH-1:0] m,
        input logic [SEL_W-1:0]  p,
        input logic              run
    );
        int               idx;
        logic             f;
        logic [SEL_W-1:0] c;
        logic [SEL_W-1:0] ci;
        f = 1'b0;
        c = p;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(p) + int'(run) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            ci = SEL_W'(idx);
            if (!f && m[ci]) begin
                f = 1'b1;
                c = ci;
            end
        end
        return {f, c};
    endfunction

    assign load    = !out_valid || out_ready;
    assign sel_bad = {1'b0, sel} >= (SEL_W+1)'(NUM_CH);
    assign {hit, scan_ch} = find_next(ch_mask, ptr, st == SCAN_RUN);
    assign nxt_ch   = mode ? scan_ch : sel;
    assign nxt_word = ch_arr[nxt_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            sel_err    <= 1'b0;
            ptr        <= '0;
            st         <= SCAN_FIRST;
`ifdef MUX_SCAN_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else begin
            sel_err <= 1'b0;
            if (load) begin
                if (!mode) begin
                    // Manual loads park the scanner so re-entry is inclusive of ptr.
                    st <= SCAN_FIRST;
                    if (sel_bad) begin
                        out_valid <= 1'b0;
                        sel_err   <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= nxt_word;
                        out_ch    <= nxt_ch;
`ifdef MUX_SCAN_PARITY_EN
                        out_parity <= ^nxt_word;
`endif
                    end
                end else if (hit) begin
                    out_valid <= 1'b1;
                    out_data  <= nxt_word;
                    out_ch    <= nxt_ch;
                    ptr       <= scan_ch;
                    st        <= SCAN_RUN;
`ifdef MUX_SCAN_PARITY_EN
                    out_parity <= ^nxt_word;
`endif
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed-vector bench for mux_scan_n: an 8-channel and a 6-channel instance.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  mask8;
    logic        rdy8;
    logic        v8;
    logic [7:0]  d8;
    logic [2:0]  c8;
    logic        e8;
    logic [47:0] in6;
    logic        mode6;
    logic [2:0]  sel6;
    logic [5:0]  mask6;
    logic        rdy6;
    logic        v6;
    logic [7:0]  d6;
    logic [2:0]  c6;
    logic        e6;
`ifdef MUX_SCAN_PARITY_EN
    logic        p8;
    logic        p6;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.WIDTH(8), .NUM_CH(8)) dut8 (
        .clk(clk), .rst(rst), .in_data(in8), .mode(mode8),
        .sel(sel8), .ch_mask(mask8), .out_ready(rdy8),
        .out_valid(v8), .out_data(d8), .out_ch(c8),
`ifdef MUX_SCAN_PARITY_EN
        .out_parity(p8),
`endif
        .sel_err(e8)
    );

    mux_scan_n #(.WIDTH(8), .NUM_CH(6)) dut6 (
        .clk(clk), .rst(rst), .in_data(in6), .mode(mode6),
        .sel(sel6), .ch_mask(mask6), .out_ready(rdy6),
        .out_valid(v6), .out_data(d6), .out_ch(c6),
`ifdef MUX_SCAN_PARITY_EN
        .out_parity(p6),
`endif
        .sel_err(e6)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++) in8[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 6; i++) in6[i*8 +: 8] = 8'h10 + 8'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int seq2 [6] = '{0, 2, 5, 7, 0, 2};

    initial begin
        fill();
        rst = 1'b1;
        mode8 = 1'b0; sel8 = '0; mask8 = '0; rdy8 = 1'b1;
        mode6 = 1'b0; sel6 = '0; mask6 = '0; rdy6 = 1'b1;
        step();
        chk("rst_valid", 32'(v8), 0);
        chk("rst_data", 32'(d8), 0);
        chk("rst_ch", 32'(c8), 0);
        chk("rst_err", 32'(e8), 0);
        rst = 1'b0;

        // 1: manual sweep
        for (int i = 0; i < 8; i++) begin
            sel8 = 3'(i);
            step();
            chk("man_data", 32'(d8), 32'h10 + 32'(i));
            chk("man_ch", 32'(c8), 32'(i));
            chk("man_valid", 32'(v8), 1);
        end

        // 2: auto-scan round robin
        do_reset();
        mode8 = 1'b1; mask8 = 8'b1010_0101;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("scan_ch", 32'(c8), 32'(seq2[i]));
            chk("scan_data", 32'(d8), 32'h10 + 32'(seq2[i]));
        end

        // 3: backpressure hold
        do_reset();
        rdy8 = 1'b0;
        step();
        chk("bp_first_ch", 32'(c8), 0);
        chk("bp_first_v", 32'(v8), 1);
        for (int i = 0; i < 3; i++) begin
            in8[7:0] = 8'hA0 + 8'(i);
            in8[23:16] = 8'hB0 + 8'(i);
            sel8 = 3'(i);
            step();
            chk("bp_hold_data", 32'(d8), 32'h10);
            chk("bp_hold_ch", 32'(c8), 0);
            chk("bp_hold_v", 32'(v8), 1);
        end
        fill();
        rdy8 = 1'b1;
        step();
        chk("bp_next_ch", 32'(c8), 2);
        chk("bp_next_data", 32'(d8), 32'h12);

        // 4: empty mask then single channel
        do_reset();
        mask8 = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_v", 32'(v8), 0);
        end
        mask8 = 8'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_ch", 32'(c8), 6);
            chk("single_data", 32'(d8), 32'h16);
            chk("single_v", 32'(v8), 1);
        end

        // mode switch: pointer kept, re-entry inclusive
        do_reset();
        mask8 = 8'b1010_0101;
        step();
        step();
        chk("sw_auto_ch", 32'(c8), 2);
        mode8 = 1'b0; sel8 = 3'd4;
        step();
        chk("sw_man_ch", 32'(c8), 4);
        mode8 = 1'b1;
        step();
        chk("sw_reentry_ch", 32'(c8), 2);
        step();
        chk("sw_run_ch", 32'(c8), 5);

        // 5: out-of-range select on 6-channel instance
        sel6 = 3'd7;
        step();
        chk("err_pulse", 32'(e6), 1);
        chk("err_valid", 32'(v6), 0);
        sel6 = 3'd5;
        step();
        chk("err_clear", 32'(e6), 0);
        chk("n6_data", 32'(d6), 32'h15);
        chk("n6_valid", 32'(v6), 1);

        // 6: reset during hold
        do_reset();
        mode8 = 1'b1; mask8 = 8'b1010_0101; rdy8 = 1'b1;
        step();
        step();
        rdy8 = 1'b0;
        step();
        chk("hold_before_rst", 32'(c8), 2);
        rst = 1'b1;
        step();
        chk("midrst_v", 32'(v8), 0);
        chk("midrst_data", 32'(d8), 0);
        chk("midrst_ch", 32'(c8), 0);
        rst = 1'b0;
        rdy8 = 1'b1;
        step();
        chk("restart_ch", 32'(c8), 0);
        chk("restart_data", 32'(d8), 32'h10);

`ifdef MUX_SCAN_PARITY_EN
        mode8 = 1'b0; sel8 = 3'd3;
        step();
        chk("parity_13", 32'(p8), 1);
        sel8 = 3'd4;
        step();
        chk("parity_14", 32'(p8), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
